// File: rtl/obstacle_placer_if.sv
// Signal bundle between the obstacle placer and its environment: request/clear
// control, generator candidate, occupancy query, head/renderer lookups, status.
interface obstacle_placer_if;
  logic       place_req;
  logic       clear;
  logic [3:0] randX;
  logic [3:0] randY;
  logic       obstacleFlag;
  logic [3:0] occ_x;
  logic [3:0] occ_y;
  logic       occupied;
  logic [3:0] headX;
  logic [3:0] headY;
  logic       hit;
  logic [3:0] pix_x;
  logic [3:0] pix_y;
  logic       pix_obstacle;
  logic       busy;
  logic       done;
  logic       fail;
  logic [3:0] obs_count;

  modport master (
    output place_req, clear, randX, randY, occupied, headX, headY, pix_x, pix_y,
    input  obstacleFlag, occ_x, occ_y, hit, pix_obstacle, busy, done, fail, obs_count
  );

  modport slave (
    input  place_req, clear, randX, randY, occupied, headX, headY, pix_x, pix_y,
    output obstacleFlag, occ_x, occ_y, hit, pix_obstacle, busy, done, fail, obs_count
  );
endinterface

// File: rtl/obstacle_placer.sv
// Samples generator candidates, rejects illegal/occupied cells with retry,
// stores accepted obstacles and answers head-collision and renderer queries.
module obstacle_placer #(
  parameter int unsigned MAX_OBS   = 8,
  parameter int unsigned MAX_TRIES = 15,
  parameter int unsigned X_MAX     = 14,
  parameter int unsigned Y_MAX     = 10
) (
  input logic              clk,
  input logic              nRst,
  obstacle_placer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CAPTURE, CHECK} state_t;

  localparam logic [3:0] OBS_FULL = 4'(MAX_OBS);
  localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);
  localparam logic [3:0] X_LIM    = 4'(X_MAX);
  localparam logic [3:0] Y_LIM    = 4'(Y_MAX);

  state_t state, state_n;

  logic [3:0]         slot_x [MAX_OBS];
  logic [3:0]         slot_y [MAX_OBS];
  logic [MAX_OBS-1:0] slot_v;
  logic [3:0]         cand_x, cand_y;
  logic [3:0]         tries;
  logic [3:0]         obs_count;
  logic               done_q, fail_q, hit_q;

  logic start, retry, commit, give_up, flag;
  logic bad, head_hit, pix_hit;

  // Slot lookups: candidate duplicate, head collision, renderer query.
  always_comb begin
    bad = (cand_x == 4'd0) || (cand_x > X_LIM) ||
          (cand_y == 4'd0) || (cand_y > Y_LIM) ||
          bus.occupied ||
          ((cand_x == bus.headX) && (cand_y == bus.headY));
    head_hit = 1'b0;
    pix_hit  = 1'b0;
    for (int unsigned i = 0; i < MAX_OBS; i++) begin
      if (slot_v[i] && (slot_x[i] == cand_x) && (slot_y[i] == cand_y))
        bad = 1'b1;
      if (slot_v[i] && (slot_x[i] == bus.headX) && (slot_y[i] == bus.headY))
        head_hit = 1'b1;
      if (slot_v[i] && (slot_x[i] == bus.pix_x) && (slot_y[i] == bus.pix_y))
        pix_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    retry   = 1'b0;
    commit  = 1'b0;
    give_up = 1'b0;
    flag    = 1'b0;
    if (bus.clear) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.place_req) begin
            if (obs_count < OBS_FULL) begin
              start   = 1'b1;
              state_n = CAPTURE;
            end else begin
              give_up = 1'b1;
            end
          end
        end
        CAPTURE: state_n = CHECK;
        CHECK: begin
          flag = 1'b1;
          if (!bad) begin
            commit  = 1'b1;
            state_n = IDLE;
          end else if (tries == LAST_TRY) begin
            give_up = 1'b1;
            state_n = IDLE;
          end else begin
            retry   = 1'b1;
            state_n = CAPTURE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      slot_v    <= '0;
      obs_count <= '0;
      tries     <= '0;
      cand_x    <= '0;
      cand_y    <= '0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      hit_q     <= 1'b0;
      for (int unsigned i = 0; i < MAX_OBS; i++) begin
        slot_x[i] <= '0;
        slot_y[i] <= '0;
      end
    end else if (bus.clear) begin
      slot_v    <= '0;
      obs_count <= '0;
      tries     <= '0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      done_q <= commit;
      fail_q <= give_up;
      hit_q  <= head_hit;
      if (start)      tries <= '0;
      else if (retry) tries <= tries + 4'd1;
      if (state == CAPTURE) begin
        cand_x <= bus.randX;
        cand_y <= bus.randY;
      end
      // Slots fill strictly in order, so obs_count doubles as the write pointer.
      if (commit) begin
        for (int unsigned i = 0; i < MAX_OBS; i++) begin
          if (obs_count == 4'(i)) begin
            slot_x[i] <= cand_x;
            slot_y[i] <= cand_y;
            slot_v[i] <= 1'b1;
          end
        end
        obs_count <= obs_count + 4'd1;
      end
    end
  end

  assign bus.obstacleFlag = flag;
  assign bus.occ_x        = cand_x;
  assign bus.occ_y        = cand_y;
  assign bus.hit          = hit_q;
  assign bus.pix_obstacle = pix_hit;
  assign bus.busy         = (state != IDLE);
  assign bus.done         = done_q;
  assign bus.fail         = fail_q;
  assign bus.obs_count    = obs_count;

endmodule

// File: tb/tb_obstacle_placer.sv
// Randomized scoreboard bench for obstacle_placer: a reference model predicts
// each request's outcome, a negedge monitor compares DUT responses.
module tb_obstacle_placer;
  localparam int MAX_OBS   = 8;
  localparam int MAX_TRIES = 15;
  localparam int X_MAX     = 14;
  localparam int Y_MAX     = 10;

  typedef struct {
    bit         is_fail;
    int         lat;
    int         flags;
    int         count;
    logic [3:0] x;
    logic [3:0] y;
    time        t0;
  } exp_t;

  logic clk = 1'b0;
  logic nRst;
  always #5 clk = ~clk;

  obstacle_placer_if bus ();

  obstacle_placer #(
    .MAX_OBS  (MAX_OBS),
    .MAX_TRIES(MAX_TRIES),
    .X_MAX    (X_MAX),
    .Y_MAX    (Y_MAX)
  ) dut (
    .clk (clk),
    .nRst(nRst),
    .bus (bus)
  );

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] cx[16];
  logic [3:0] cy[16];
  int         gen_idx = 0;
  bit         snake_map[16][16];
  bit         force_occ = 1'b0;
  int         mx[$];
  int         my[$];

  // Environment: generator presents cx/cy[gen_idx], occupancy from snake map.
  always_comb bus.randX = cx[gen_idx[3:0]];
  always_comb bus.randY = cy[gen_idx[3:0]];
  always_comb bus.occupied = force_occ | snake_map[bus.occ_x][bus.occ_y];

  always @(negedge clk) if (nRst && bus.obstacleFlag) gen_idx++;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_has(input int x, input int y);
    for (int i = 0; i < mx.size(); i++)
      if (mx[i] == x && my[i] == y) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit cell_ok(input int x, input int y);
    if (x < 1 || x > X_MAX || y < 1 || y > Y_MAX) return 1'b0;
    if (force_occ || snake_map[x][y]) return 1'b0;
    if (x == int'(bus.headX) && y == int'(bus.headY)) return 1'b0;
    return !model_has(x, y);
  endfunction

  // Monitor: pops the scoreboard on every done/fail.
  int   flags_seen = 0;
  bit   prev_flag  = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!nRst) begin
      flags_seen = 0;
      prev_flag  = 1'b0;
    end else begin
      if (bus.obstacleFlag) begin
        flags_seen++;
        check("flag_back_to_back", int'(prev_flag), 0);
        check("flag_without_request", int'(sb.size() != 0), 1);
      end
      if (bus.done || bus.fail) begin
        if (sb.size() == 0) begin
          check("output_without_request", int'(bus.done) + int'(bus.fail), 0);
        end else begin
          mon_e = sb.pop_front();
          check("result_is_fail", int'(bus.fail), int'(mon_e.is_fail));
          check("result_is_done", int'(bus.done), int'(!mon_e.is_fail));
          check("latency", int'(($time - mon_e.t0) / 10), mon_e.lat);
          check("flag_count", flags_seen, mon_e.flags);
          check("obs_count", int'(bus.obs_count), mon_e.count);
        end
        flags_seen = 0;
      end
      prev_flag = bus.obstacleFlag;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("response_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic request();
    exp_t e;
    bit   found = 1'b0;
    e.x = '0;
    e.y = '0;
    if (mx.size() >= MAX_OBS) begin
      e.is_fail = 1'b1; e.lat = 1; e.flags = 0;
    end else begin
      for (int k = 0; k < MAX_TRIES; k++) begin
        if (!found && cell_ok(int'(cx[k]), int'(cy[k]))) begin
          found = 1'b1; e.lat = 2 * k + 3; e.flags = k + 1;
          e.x = cx[k]; e.y = cy[k];
        end
      end
      if (found) begin
        e.is_fail = 1'b0;
        mx.push_back(int'(e.x));
        my.push_back(int'(e.y));
      end else begin
        e.is_fail = 1'b1; e.lat = 2 * MAX_TRIES + 1; e.flags = MAX_TRIES;
      end
    end
    e.count = mx.size();
    gen_idx = 0;
    tick();
    bus.place_req = 1'b1;
    e.t0 = $time;
    sb.push_back(e);
    tick();
    bus.place_req = 1'b0;
    if (e.lat == 1) check("busy_when_full", int'(bus.busy), 0);
    wait_idle();
    if (!e.is_fail) begin
      bus.pix_x = e.x;
      bus.pix_y = e.y;
      #1 check("pix_new_obstacle", int'(bus.pix_obstacle), 1);
    end
    @(negedge clk);
    check("hit", int'(bus.hit), int'(model_has(int'(bus.headX), int'(bus.headY))));
  endtask

  task automatic clear_snake();
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) snake_map[x][y] = 1'b0;
  endtask

  task automatic randomize_env();
    int r, j;
    clear_snake();
    repeat (3) snake_map[$urandom_range(1, 14)][$urandom_range(1, 10)] = 1'b1;
    bus.headX = 4'($urandom_range(1, 14));
    bus.headY = 4'($urandom_range(1, 10));
    for (int k = 0; k < 16; k++) begin
      r = $urandom_range(0, 9);
      cx[k] = 4'($urandom_range(1, 14));
      cy[k] = 4'($urandom_range(1, 10));
      if (r == 0) cx[k] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(15, 15));
      if (r == 1) cy[k] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(11, 15));
      if (r == 2) begin cx[k] = bus.headX; cy[k] = bus.headY; end
      if (r == 3 && mx.size() > 0) begin
        j = $urandom_range(0, mx.size() - 1);
        cx[k] = 4'(mx[j]); cy[k] = 4'(my[j]);
      end
    end
  endtask

  task automatic pix_probe();
    int x, y, j;
    for (int i = 0; i < 8; i++) begin
      x = $urandom_range(0, 15);
      y = $urandom_range(0, 15);
      if (i % 2 == 0 && mx.size() > 0) begin
        j = $urandom_range(0, mx.size() - 1);
        x = mx[j]; y = my[j];
      end
      bus.pix_x = 4'(x);
      bus.pix_y = 4'(y);
      #1 check("pix_probe", int'(bus.pix_obstacle), int'(model_has(x, y)));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_fail"}, int'(bus.fail), 0);
    check({tag, "_flag"}, int'(bus.obstacleFlag), 0);
    check({tag, "_obs_count"}, int'(bus.obs_count), 0);
    check({tag, "_hit"}, int'(bus.hit), 0);
    check({tag, "_occ_x"}, int'(bus.occ_x), 0);
    check({tag, "_occ_y"}, int'(bus.occ_y), 0);
    check({tag, "_pix"}, int'(bus.pix_obstacle), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    bus.place_req = 1'b0;
    bus.clear     = 1'b0;
    bus.headX     = 4'd1;
    bus.headY     = 4'd1;
    bus.pix_x     = 4'd0;
    bus.pix_y     = 4'd0;
    for (int k = 0; k < 16; k++) begin cx[k] = '0; cy[k] = '0; end
    clear_snake();
    nRst = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 nRst = 1'b1;

    // First-try accept at (3,4).
    cx[0] = 4'd3; cy[0] = 4'd4;
    request();

    // Two occupied candidates, third accepted.
    snake_map[2][2] = 1'b1;
    snake_map[6][6] = 1'b1;
    cx[0] = 4'd2; cy[0] = 4'd2;
    cx[1] = 4'd6; cy[1] = 4'd6;
    cx[2] = 4'd9; cy[2] = 4'd9;
    request();
    clear_snake();

    // Occupancy always reported: tries exhausted.
    force_occ = 1'b1;
    randomize_env();
    bus.headX = 4'd1; bus.headY = 4'd1;
    request();
    force_occ = 1'b0;
    clear_snake();

    // Head collision: store (5,2), move head there, reject (5,2)/(15,2).
    bus.headX = 4'd1; bus.headY = 4'd1;
    cx[0] = 4'd5; cy[0] = 4'd2;
    request();
    bus.headX = 4'd5; bus.headY = 4'd2;
    @(posedge clk);
    @(negedge clk);
    check("hit_after_head_move", int'(bus.hit), 1);
    cx[0] = 4'd5;  cy[0] = 4'd2;
    cx[1] = 4'd15; cy[1] = 4'd2;
    cx[2] = 4'd7;  cy[2] = 4'd7;
    request();

    // Clear asserted while the DUT sits in CHECK.
    bus.headX = 4'(mx[0]); bus.headY = 4'(my[0]);
    @(posedge clk);
    @(negedge clk);
    check("hit_before_clear", int'(bus.hit), 1);
    cx[0] = 4'd10; cy[0] = 4'd10;
    gen_idx = 0;
    tick(); bus.place_req = 1'b1;
    tick(); bus.place_req = 1'b0;
    tick(); bus.clear = 1'b1;
    tick(); bus.clear = 1'b0;
    @(negedge clk);
    check("clear_busy", int'(bus.busy), 0);
    check("clear_obs_count", int'(bus.obs_count), 0);
    check("clear_hit", int'(bus.hit), 0);
    bus.pix_x = 4'd3; bus.pix_y = 4'd4;
    #1 check("clear_pix", int'(bus.pix_obstacle), 0);
    repeat (3) @(negedge clk);
    mx.delete(); my.delete();

    // Random fill, then deterministic top-up until full.
    guard = 0;
    while (mx.size() < MAX_OBS && guard < 30) begin
      randomize_env();
      request();
      guard++;
    end
    clear_snake();
    bus.headX = 4'd1; bus.headY = 4'd1;
    for (int x = 1; x <= X_MAX && mx.size() < MAX_OBS; x++) begin
      if (cell_ok(x, 5)) begin
        cx[0] = 4'(x); cy[0] = 4'd5;
        request();
      end
    end
    check("field_full", int'(bus.obs_count), MAX_OBS);

    // Full field: immediate fail, no generator activity.
    randomize_env();
    request();
    pix_probe();

    // Idle clear, then one placement before an async reset mid-request.
    tick(); bus.clear = 1'b1;
    tick(); bus.clear = 1'b0;
    mx.delete(); my.delete();
    @(negedge clk);
    check("idle_clear_obs_count", int'(bus.obs_count), 0);
    clear_snake();
    bus.headX = 4'd1; bus.headY = 4'd1;
    cx[0] = 4'd7; cy[0] = 4'd3;
    request();
    cx[0] = 4'd8; cy[0] = 4'd8;
    gen_idx = 0;
    tick(); bus.place_req = 1'b1;
    tick(); bus.place_req = 1'b0;
    #2 nRst = 1'b0;
    bus.pix_x = 4'd7; bus.pix_y = 4'd3;
    #1 check_reset_outputs("async_reset");
    mx.delete(); my.delete();
    @(negedge clk);
    nRst = 1'b1;

    cx[0] = 4'd12; cy[0] = 4'd9;
    request();
    pix_probe();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
